counter_subtractor: RTL

Sequential subtractor built from two down-counters and a small controller; the decrementing counterpart of the team's up-counter/adder block. On `start` it loads operands `a` and `b` into two counters. It decrements both in lockstep until either reaches zero, then reports `a - b` modulo 2^WIDTH with a borrow flag. It serves as a reusable arithmetic sub-unit for the basic-cpu datapath experiments.

---
 rtl/counter_subtractor.sv | 79 +++++++
 1 files changed

// File: rtl/counter_subtractor.sv
// Sequential subtractor: two down-counters run in lockstep until one reaches zero.
// The survivor (or its two's complement) is the result a - b mod 2^WIDTH.
module counter_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_cnt1;
   logic [WIDTH-1:0] r_cnt2;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             w_both_nz;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   assign w_both_nz = (r_cnt1 != '0) && (r_cnt2 != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt1   <= '0;
         r_cnt2   <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt1  <= a;
                  r_cnt2  <= b;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_both_nz) begin
                  r_cnt1 <= r_cnt1 - WIDTH'(1);
                  r_cnt2 <= r_cnt2 - WIDTH'(1);
               end else begin
                  // cnt1 left over means a >= b; cnt2 left over means a - b wrapped negative
                  if (r_cnt2 == '0) begin
                     r_diff   <= r_cnt1;
                     r_borrow <= 1'b0;
                  end else begin
                     r_diff   <= negate(r_cnt2);
                     r_borrow <= 1'b1;
                  end
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy   = (r_state != IDLE);
   assign done   = (r_state == DONE);
   assign diff   = r_diff;
   assign borrow = r_borrow;

endmodule
